// File: rtl/instr_sequencer.sv
// Multi-cycle instruction sequencer: fetch/decode/exec/mem/wb control with branch resolution.
// Define INSTR_SEQ_RET_STACK_EN to add a 4-entry return-address stack for call/ret.
module instr_sequencer (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        dec_mem_read,
    input  logic        dec_mem_write,
    input  logic        dec_reg_write,
    input  logic        dec_halt,
    input  logic        dec_b,
    input  logic        dec_bz,
    input  logic        dec_bnz,
    input  logic        dec_bcy,
    input  logic        dec_bncy,
    input  logic        dec_bs,
    input  logic        dec_bns,
    input  logic        dec_bv,
    input  logic        dec_bnv,
    input  logic        dec_call,
    input  logic        dec_ret,
    input  logic        alu_z,
    input  logic        alu_cy,
    input  logic        alu_s,
    input  logic        alu_v,
    input  logic        flags_we,
    output logic        imem_req,
    input  logic        imem_ack,
    output logic        dmem_req,
    output logic        dmem_we,
    input  logic        dmem_ack,
    input  logic [31:0] pc_plus1,
    output logic        ir_we,
    output logic        rf_we,
    output logic        pc_we,
    output logic [1:0]  pc_sel,
    output logic [31:0] ret_addr,
    output logic [3:0]  flags,
    output logic [2:0]  state,
    output logic        busy,
    output logic        halted,
    output logic        err
);

    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StFetch  = 3'd1,
        StDecode = 3'd2,
        StExec   = 3'd3,
        StMem    = 3'd4,
        StWb     = 3'd5,
        StHalt   = 3'd6
    } state_e;

    state_e      state_q, state_d;
    logic [3:0]  flags_q, flags_d;
    logic        taken_q, taken_d;
    logic        call_q, call_d;
    logic        ret_q, ret_d;
    logic        err_q, err_d;

    logic        mem_op;
    logic        cond_taken;
    logic        complete;
    logic        stack_err;
    logic        flag_z, flag_cy, flag_s, flag_v;

    assign {flag_z, flag_cy, flag_s, flag_v} = flags_q;
    assign mem_op = dec_mem_read | dec_mem_write;

    assign cond_taken = (dec_bz   &  flag_z)  | (dec_bnz  & ~flag_z)  |
                        (dec_bcy  &  flag_cy) | (dec_bncy & ~flag_cy) |
                        (dec_bs   &  flag_s)  | (dec_bns  & ~flag_s)  |
                        (dec_bv   &  flag_v)  | (dec_bnv  & ~flag_v);

    // Resolved in EXEC from the pre-update flags; the _d view is valid in the EXEC cycle too.
    always_comb begin
        taken_d = taken_q;
        call_d  = call_q;
        ret_d   = ret_q;
        if (state_q == StExec) begin
            taken_d = dec_b | dec_call | dec_ret | cond_taken;
            call_d  = ~dec_b & dec_call;
            ret_d   = ~dec_b & ~dec_call & dec_ret;
        end
    end

    assign complete = ((state_q == StExec) & ~mem_op & ~dec_reg_write) |
                      ((state_q == StMem) & dmem_ack & ~dec_mem_read) |
                      (state_q == StWb);

`ifdef INSTR_SEQ_RET_STACK_EN
    logic [31:0] stack_q [4];
    logic [2:0]  sp_q;
    logic        push, pop;

    assign push      = complete & call_d;
    assign pop       = complete & ret_d;
    assign stack_err = (push & (sp_q == 3'd4)) | (pop & (sp_q == 3'd0));
    assign ret_addr  = (sp_q == 3'd0) ? 32'd0 : stack_q[sp_q[1:0] - 2'd1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sp_q <= 3'd0;
            for (int i = 0; i < 4; i++) begin
                stack_q[i] <= 32'd0;
            end
        end else if ((state_q == StHalt) && start) begin
            sp_q <= 3'd0;
        end else if (!stack_err) begin
            if (push) begin
                stack_q[sp_q[1:0]] <= pc_plus1;
                sp_q               <= sp_q + 3'd1;
            end else if (pop) begin
                sp_q <= sp_q - 3'd1;
            end
        end
    end
`else
    logic unused_stack;

    // Without a stack a call is an ordinary jump and ret redirects to a constant zero.
    assign unused_stack = ^{pc_plus1, call_d};
    assign stack_err    = 1'b0;
    assign ret_addr     = 32'd0;
`endif

    always_comb begin
        state_d  = state_q;
        flags_d  = flags_q;
        err_d    = err_q;
        imem_req = 1'b0;
        dmem_req = 1'b0;
        dmem_we  = 1'b0;
        ir_we    = 1'b0;
        rf_we    = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start) state_d = StFetch;
            end
            StFetch: begin
                imem_req = 1'b1;
                if (imem_ack) begin
                    ir_we   = 1'b1;
                    state_d = StDecode;
                end
            end
            StDecode: begin
                state_d = dec_halt ? StHalt : StExec;
            end
            StExec: begin
                if (flags_we) flags_d = {alu_z, alu_cy, alu_s, alu_v};
                if (mem_op) begin
                    state_d = StMem;
                end else if (dec_reg_write) begin
                    state_d = StWb;
                end
            end
            StMem: begin
                dmem_req = 1'b1;
                dmem_we  = dec_mem_write;
                if (dmem_ack && dec_mem_read) state_d = StWb;
            end
            StWb: begin
                rf_we = 1'b1;
            end
            StHalt: begin
                if (start) begin
                    err_d   = 1'b0;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
        if (complete) begin
            if (stack_err) begin
                err_d   = 1'b1;
                state_d = StHalt;
            end else begin
                state_d = StFetch;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            flags_q <= 4'd0;
            taken_q <= 1'b0;
            call_q  <= 1'b0;
            ret_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            flags_q <= flags_d;
            taken_q <= taken_d;
            call_q  <= call_d;
            ret_q   <= ret_d;
            err_q   <= err_d;
        end
    end

    assign pc_we  = complete & ~stack_err;
    assign pc_sel = !pc_we ? 2'd0 : (ret_d ? 2'd2 : (taken_d ? 2'd1 : 2'd0));
    assign flags  = flags_q;
    assign state  = state_q;
    assign busy   = (state_q != StIdle) && (state_q != StHalt);
    assign halted = (state_q == StHalt);
    assign err    = err_q;

endmodule

// File: tb/tb_instr_sequencer.sv
// Self-checking bench for instr_sequencer: directed scenarios plus a randomised instruction
// stream compared against a per-instruction timing, branch, flag and return-stack model.
`timescale 1ns/1ps
module tb_instr_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        dec_mem_read = 1'b0, dec_mem_write = 1'b0, dec_reg_write = 1'b0;
    logic        dec_halt = 1'b0;
    logic        dec_b = 1'b0, dec_bz = 1'b0, dec_bnz = 1'b0, dec_bcy = 1'b0, dec_bncy = 1'b0;
    logic        dec_bs = 1'b0, dec_bns = 1'b0, dec_bv = 1'b0, dec_bnv = 1'b0;
    logic        dec_call = 1'b0, dec_ret = 1'b0;
    logic        alu_z = 1'b0, alu_cy = 1'b0, alu_s = 1'b0, alu_v = 1'b0, flags_we = 1'b0;
    logic        imem_ack = 1'b0, dmem_ack = 1'b0;
    logic [31:0] pc_plus1 = 32'd0;
    logic        imem_req, dmem_req, dmem_we, ir_we, rf_we, pc_we;
    logic [1:0]  pc_sel;
    logic [31:0] ret_addr;
    logic [3:0]  flags;
    logic [2:0]  state;
    logic        busy, halted, err;

    int n_total = 0;
    int n_pass  = 0;

    // Per-instruction observations gathered by run_instr.
    int          r_cyc, r_irc, r_rfn, r_pcn, r_dreq, r_dwe;
    logic [1:0]  r_sel;
    logic [31:0] r_ra;
    bit          r_halt, r_to;

    // Reference architectural state.
    logic [3:0]  m_flags;
    logic [31:0] m_stack[$];

    always #5 clk = ~clk;

    instr_sequencer dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .dec_mem_read  (dec_mem_read),
        .dec_mem_write (dec_mem_write),
        .dec_reg_write (dec_reg_write),
        .dec_halt      (dec_halt),
        .dec_b         (dec_b),
        .dec_bz        (dec_bz),
        .dec_bnz       (dec_bnz),
        .dec_bcy       (dec_bcy),
        .dec_bncy      (dec_bncy),
        .dec_bs        (dec_bs),
        .dec_bns       (dec_bns),
        .dec_bv        (dec_bv),
        .dec_bnv       (dec_bnv),
        .dec_call      (dec_call),
        .dec_ret       (dec_ret),
        .alu_z         (alu_z),
        .alu_cy        (alu_cy),
        .alu_s         (alu_s),
        .alu_v         (alu_v),
        .flags_we      (flags_we),
        .imem_req      (imem_req),
        .imem_ack      (imem_ack),
        .dmem_req      (dmem_req),
        .dmem_we       (dmem_we),
        .dmem_ack      (dmem_ack),
        .pc_plus1      (pc_plus1),
        .ir_we         (ir_we),
        .rf_we         (rf_we),
        .pc_we         (pc_we),
        .pc_sel        (pc_sel),
        .ret_addr      (ret_addr),
        .flags         (flags),
        .state         (state),
        .busy          (busy),
        .halted        (halted),
        .err           (err)
    );

    // Branch vector bit order: 0 b, 1 call, 2 ret, 3 bz, 4 bnz, 5 bcy, 6 bncy, 7 bs, 8 bns,
    // 9 bv, 10 bnv.  Flags are {Z,CY,S,V}.
    task automatic set_dec(input logic mr, mw, rw, hl, input logic [10:0] br, input logic fwe,
                           input logic [3:0] af, input logic [31:0] pp);
        dec_mem_read = mr; dec_mem_write = mw; dec_reg_write = rw; dec_halt = hl;
        {dec_bnv, dec_bv, dec_bns, dec_bs, dec_bncy, dec_bcy, dec_bnz, dec_bz,
         dec_ret, dec_call, dec_b} = br;
        flags_we = fwe;
        {alu_z, alu_cy, alu_s, alu_v} = af;
        pc_plus1 = pp;
    endtask

    function automatic void model_branch(input logic [10:0] br, input logic [3:0] f,
                                         output logic tk, output int kind);
        tk = 1'b0;
        kind = 0;
        if (br[0]) tk = 1'b1;
        else if (br[1]) begin tk = 1'b1; kind = 1; end
        else if (br[2]) begin tk = 1'b1; kind = 2; end
        else begin
            for (int i = 3; i < 11; i++) begin
                if (br[i] && (f[3 - (i - 3) / 2] ^ (((i - 3) % 2) == 1))) tk = 1'b1;
            end
        end
`ifndef INSTR_SEQ_RET_STACK_EN
        if (kind == 1) kind = 0;
`endif
    endfunction

    task automatic do_reset();
        set_dec(0, 0, 0, 0, '0, 0, '0, '0);
        start = 0; imem_ack = 0; dmem_ack = 0;
        rst_n = 0;
        repeat (2) @(negedge clk);
        rst_n = 1;
        m_flags = 4'd0;
        m_stack.delete();
    endtask

    task automatic kick();
        @(negedge clk); start = 1;
        @(posedge clk); #1; start = 0;
    endtask

    // Runs one instruction from its first FETCH cycle, acting as both memories.
    task automatic run_instr(input int id, input int dd, input bit noise);
        int iw, dw;
        bit done;
        iw = 0; dw = 0; done = 0;
        r_cyc = 0; r_irc = -1; r_rfn = 0; r_pcn = 0; r_dreq = 0; r_dwe = 0;
        r_sel = '0; r_ra = '0; r_halt = 0; r_to = 0;
        while (!done) begin
            @(negedge clk);
            imem_ack = 0; dmem_ack = 0; start = 0;
            #1;
            if (state === 3'd6) begin
                r_halt = 1; done = 1;
            end else begin
                if (noise) start = 1'($urandom_range(0, 1));
                if (imem_req === 1'b1) begin imem_ack = (iw == id); iw++; end
                if (dmem_req === 1'b1) begin dmem_ack = (dw == dd); dw++; end
                #1;
                if (ir_we === 1'b1) r_irc = r_cyc;
                if (rf_we === 1'b1) r_rfn++;
                if (dmem_req === 1'b1) r_dreq++;
                if (dmem_we === 1'b1) r_dwe++;
                if (pc_we === 1'b1) begin r_pcn++; r_sel = pc_sel; r_ra = ret_addr; done = 1; end
                r_cyc++;
                if (r_cyc >= 64) begin r_to = 1; done = 1; end
            end
        end
        if (!r_halt) begin
            @(posedge clk); #1;
            imem_ack = 0; dmem_ack = 0; start = 0;
        end
    endtask

    task automatic test_reset();
        set_dec(1, 1, 1, 0, 11'h7ff, 1, 4'hf, 32'hdead_beef);
        start = 1; imem_ack = 1; dmem_ack = 1; rst_n = 0;
        @(negedge clk); #1;
        n_total++; if (state !== 3'd0) $display("FAIL reset_state: got %0d want 0", state);
        else n_pass++;
        n_total++; if (flags !== 4'd0 || err !== 1'b0)
            $display("FAIL reset_flags_err: got flags=%b err=%b want 0000/0", flags, err);
        else n_pass++;
        n_total++; if ({ir_we, rf_we, pc_we, imem_req, dmem_req, dmem_we} !== 6'd0)
            $display("FAIL reset_strobes: got %b want 000000",
                     {ir_we, rf_we, pc_we, imem_req, dmem_req, dmem_we});
        else n_pass++;
        n_total++; if (pc_sel !== 2'd0 || ret_addr !== 32'd0 || busy !== 1'b0 || halted !== 1'b0)
            $display("FAIL reset_outputs: got sel=%0d ra=%h busy=%b halted=%b want 0/0/0/0",
                     pc_sel, ret_addr, busy, halted);
        else n_pass++;
        do_reset();
    endtask

    task automatic test_alu_op();
        do_reset(); kick();
        set_dec(0, 0, 1, 0, '0, 1, 4'b1000, 32'd0);
        run_instr(0, 0, 0);
        n_total++; if (r_to || r_irc != 0)
            $display("FAIL alu_ir_we: got fetch-relative cycle %0d want 0", r_irc);
        else n_pass++;
        n_total++; if (r_cyc != 4 || r_rfn != 1 || r_pcn != 1)
            $display("FAIL alu_timing: got cycles=%0d rf_we=%0d pc_we=%0d want 4/1/1",
                     r_cyc, r_rfn, r_pcn);
        else n_pass++;
        n_total++; if (r_sel !== 2'd0) $display("FAIL alu_pc_sel: got %0d want 0", r_sel);
        else n_pass++;
        n_total++; if (flags !== 4'b1000) $display("FAIL alu_flags: got %b want 1000", flags);
        else n_pass++;
    endtask

    task automatic test_branch();
        set_dec(0, 0, 0, 0, 11'b000_0000_1000, 0, 4'b0000, 32'd0);
        run_instr(0, 0, 0);
        n_total++; if (r_pcn != 1 || r_sel !== 2'd1 || r_cyc != 3)
            $display("FAIL bz_taken: got pc_we=%0d sel=%0d cycles=%0d want 1/1/3",
                     r_pcn, r_sel, r_cyc);
        else n_pass++;
        set_dec(0, 0, 0, 0, 11'b000_0001_0000, 0, 4'b0000, 32'd0);
        run_instr(0, 0, 0);
        n_total++; if (r_pcn != 1 || r_sel !== 2'd0)
            $display("FAIL bnz_not_taken: got pc_we=%0d sel=%0d want 1/0", r_pcn, r_sel);
        else n_pass++;
    endtask

    task automatic test_load_wait();
        do_reset(); kick();
        set_dec(1, 0, 0, 0, '0, 0, '0, '0);
        run_instr(0, 3, 0);
        n_total++; if (r_dreq != 4 || r_dwe != 0)
            $display("FAIL load_dmem: got req=%0d we=%0d cycles want 4/0", r_dreq, r_dwe);
        else n_pass++;
        n_total++; if (r_rfn != 1 || r_pcn != 1 || r_cyc + 1 != 9)
            $display("FAIL load_total: got rf_we=%0d pc_we=%0d total=%0d want 1/1/9",
                     r_rfn, r_pcn, r_cyc + 1);
        else n_pass++;
    endtask

    task automatic test_call_ret();
        do_reset(); kick();
        set_dec(0, 0, 0, 0, 11'b000_0000_0010, 0, '0, 32'h10);
        run_instr(0, 0, 0);
        n_total++; if (r_pcn != 1 || r_sel !== 2'd1)
            $display("FAIL call_sel: got pc_we=%0d sel=%0d want 1/1", r_pcn, r_sel);
        else n_pass++;
        set_dec(0, 0, 0, 0, 11'b000_0000_0100, 0, '0, 32'h77);
        run_instr(0, 0, 0);
        n_total++; if (r_pcn != 1 || r_sel !== 2'd2)
            $display("FAIL ret_sel: got pc_we=%0d sel=%0d want 1/2", r_pcn, r_sel);
        else n_pass++;
`ifdef INSTR_SEQ_RET_STACK_EN
        n_total++; if (r_ra !== 32'h10) $display("FAIL ret_addr: got %h want 00000010", r_ra);
        else n_pass++;
        for (int k = 0; k < 5; k++) begin
            set_dec(0, 0, 0, 0, 11'b000_0000_0010, 0, '0, 32'h100 + k);
            run_instr(0, 0, 0);
            n_total++; if (r_halt != (k == 4) || r_pcn != (k == 4 ? 0 : 1))
                $display("FAIL nested_call%0d: got halt=%0d pc_we=%0d want %0d/%0d",
                         k, r_halt, r_pcn, k == 4, k == 4 ? 0 : 1);
            else n_pass++;
        end
        n_total++; if (err !== 1'b1 || halted !== 1'b1)
            $display("FAIL overflow_err: got err=%b halted=%b want 1/1", err, halted);
        else n_pass++;
        @(negedge clk); start = 1; @(posedge clk); #1; start = 0;
        n_total++; if (state !== 3'd0 || err !== 1'b0 || ret_addr !== 32'd0)
            $display("FAIL halt_clear: got state=%0d err=%b ra=%h want 0/0/0",
                     state, err, ret_addr);
        else n_pass++;
`else
        n_total++; if (r_ra !== 32'd0) $display("FAIL ret_addr_nostack: got %h want 0", r_ra);
        else n_pass++;
`endif
    endtask

    task automatic test_reset_mid_mem();
        do_reset(); kick();
        set_dec(1, 0, 1, 0, '0, 0, '0, '0);
        for (int k = 0; k < 8 && state !== 3'd4; k++) begin
            @(negedge clk); imem_ack = 1; @(posedge clk); #1;
        end
        imem_ack = 0;
        n_total++; if (state !== 3'd4) $display("FAIL reach_mem: got state %0d want 4", state);
        else n_pass++;
        @(negedge clk); #2;
        rst_n = 0; #1;
        n_total++; if (state !== 3'd0 || dmem_req !== 1'b0 || busy !== 1'b0)
            $display("FAIL async_reset: got state=%0d dmem_req=%b busy=%b want 0/0/0",
                     state, dmem_req, busy);
        else n_pass++;
        @(negedge clk); rst_n = 1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk); dmem_ack = 1; #1;
            n_total++; if (state !== 3'd0 || {rf_we, pc_we, dmem_req} !== 3'd0)
                $display("FAIL late_ack%0d: got state=%0d rf/pc/req=%b want 0/000",
                         k, state, {rf_we, pc_we, dmem_req});
            else n_pass++;
        end
        dmem_ack = 0;
    endtask

    task automatic test_random();
        int          id, dd, cls, kind, exp_cyc, exp_dreq, exp_dwe, exp_rfn;
        logic        mr, mw, rw, hl, fwe, mem, wb, serr, tk;
        logic [10:0] br;
        logic [3:0]  af;
        logic [31:0] pp, exp_ra;
        logic [1:0]  exp_sel;
        do_reset(); kick();
        for (int it = 0; it < 40; it++) begin
            cls = $urandom_range(0, 9);
            mr = 0; mw = 0; rw = 0; hl = 0; br = '0;
            fwe = 1'($urandom_range(0, 1)); af = 4'($urandom); pp = $urandom;
            id = $urandom_range(0, 3); dd = $urandom_range(0, 3);
            case (cls)
                0, 1, 2: rw = 1;
                3: begin mr = 1; rw = 1'($urandom_range(0, 1)); end
                4: begin mw = 1; rw = 1'($urandom_range(0, 1)); end
                5, 6, 7: begin
                    br[$urandom_range(0, 10)] = 1'b1;
                    if ($urandom_range(0, 3) == 0) br[$urandom_range(0, 2)] = 1'b1;
                end
                8: ;
                default: hl = 1;
            endcase
            mem = mr | mw;
            wb  = mem ? mr : rw;
            model_branch(br, m_flags, tk, kind);
            exp_sel = !tk ? 2'd0 : (kind == 2 ? 2'd2 : 2'd1);
            exp_ra  = 32'd0;
            serr    = 0;
`ifdef INSTR_SEQ_RET_STACK_EN
            if (m_stack.size() > 0) exp_ra = m_stack[$];
            if (tk && kind == 1 && m_stack.size() == 4) serr = 1;
            if (tk && kind == 2 && m_stack.size() == 0) serr = 1;
`endif
            exp_cyc  = hl ? id + 2 : id + 3 + (mem ? dd + 1 : 0) + (wb ? 1 : 0);
            exp_dreq = (!hl && mem) ? dd + 1 : 0;
            exp_dwe  = (!hl && mw) ? dd + 1 : 0;
            exp_rfn  = (!hl && wb) ? 1 : 0;
            if (!hl && fwe) m_flags = af;
`ifdef INSTR_SEQ_RET_STACK_EN
            if (!hl && !serr && tk && kind == 1) m_stack.push_back(pp);
            if (!hl && !serr && tk && kind == 2) void'(m_stack.pop_back());
`endif
            set_dec(mr, mw, rw, hl, br, fwe, af, pp);
            run_instr(id, dd, 1);

            n_total++; if (r_to) $display("FAIL rnd%0d_timeout: got none in 64 cycles", it);
            else n_pass++;
            n_total++; if (r_cyc != exp_cyc)
                $display("FAIL rnd%0d_cycles: got %0d want %0d", it, r_cyc, exp_cyc);
            else n_pass++;
            n_total++; if (r_halt != (hl | serr))
                $display("FAIL rnd%0d_halt: got %0d want %0d", it, r_halt, hl | serr);
            else n_pass++;
            n_total++; if (r_irc != id)
                $display("FAIL rnd%0d_ir_we: got cycle %0d want %0d", it, r_irc, id);
            else n_pass++;
            n_total++; if (r_rfn != exp_rfn || r_dreq != exp_dreq || r_dwe != exp_dwe)
                $display("FAIL rnd%0d_strobes: got rf=%0d req=%0d we=%0d want %0d/%0d/%0d",
                         it, r_rfn, r_dreq, r_dwe, exp_rfn, exp_dreq, exp_dwe);
            else n_pass++;
            n_total++; if (flags !== m_flags)
                $display("FAIL rnd%0d_flags: got %b want %b", it, flags, m_flags);
            else n_pass++;
            if (hl | serr) begin
                n_total++; if (err !== serr || r_pcn != 0)
                    $display("FAIL rnd%0d_halt_state: got err=%b pc_we=%0d want %b/0",
                             it, err, r_pcn, serr);
                else n_pass++;
                @(negedge clk); start = 1; @(posedge clk); #1; start = 0;
                n_total++; if (state !== 3'd0 || err !== 1'b0)
                    $display("FAIL rnd%0d_recover: got state=%0d err=%b want 0/0",
                             it, state, err);
                else n_pass++;
                m_stack.delete();
                kick();
            end else begin
                n_total++; if (r_pcn != 1 || r_sel !== exp_sel)
                    $display("FAIL rnd%0d_pc_sel: got pc_we=%0d sel=%0d want 1/%0d",
                             it, r_pcn, r_sel, exp_sel);
                else n_pass++;
                n_total++; if (r_ra !== exp_ra)
                    $display("FAIL rnd%0d_ret_addr: got %h want %h", it, r_ra, exp_ra);
                else n_pass++;
            end
        end
    endtask

    initial begin
        test_reset();
        test_alu_op();
        test_branch();
        test_load_wait();
        test_call_ret();
        test_reset_mid_mem();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish by 500us want finish");
        $fatal(1, "watchdog expired");
    end

endmodule
